// File: rtl/cnt_pkg.sv
// ============================================================================
//  Module   : cnt_pkg
//  Brief    : Shared types, reset values and the modulus legality helper
//             for sync_updown_counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cnt_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   localparam int   RST_COUNT = 0;
   localparam logic RST_WRAP  = 1'b0;
   localparam logic RST_OVF   = 1'b0;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;

   function automatic bit mod_is_legal(input int width, input int modulus);
      return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
             (modulus >= 2) && (modulus <= (1 << width));
   endfunction

endpackage

`default_nettype wire

// File: rtl/mod_limit_detect.sv
// ============================================================================
//  Module   : mod_limit_detect
//  Brief    : Combinational terminal-count detect and next-count value for a
//             modulo-MOD up/down counter. Honours CNT_SATURATE_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_limit_detect
   import cnt_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic [WIDTH-1:0] i_q,
   input  dir_t             i_dir,
   output logic [WIDTH-1:0] o_next,
   output logic             o_at_limit
);

   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

   logic w_at_max;
   logic w_at_min;

   always_comb begin
      w_at_max   = (i_q == c_MAX);
      w_at_min   = (i_q == '0);
      o_at_limit = (i_dir == DIR_UP) ? w_at_max : w_at_min;
   end

`ifdef CNT_SATURATE_EN
   // Past the limit the count simply stays put.
   always_comb begin
      if (o_at_limit)
         o_next = i_q;
      else if (i_dir == DIR_UP)
         o_next = i_q + c_ONE;
      else
         o_next = i_q - c_ONE;
   end
`else
   always_comb begin
      if (i_dir == DIR_UP)
         o_next = w_at_max ? '0 : (i_q + c_ONE);
      else
         o_next = w_at_min ? c_MAX : (i_q - c_ONE);
   end
`endif

endmodule

`default_nettype wire

// File: rtl/sync_updown_counter.sv
// ============================================================================
//  Module   : sync_updown_counter
//  Brief    : Synchronous up/down modulo-MOD counter with load, terminal
//             count, wrap pulse and sticky overflow. Build option
//             CNT_SATURATE_EN turns wrapping into saturation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_updown_counter
   import cnt_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   generate
      if (!mod_is_legal(WIDTH, MOD)) begin : g_mod_illegal
         $error("sync_updown_counter: illegal WIDTH/MOD combination");
      end
   endgenerate

   localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH+1)'(MOD);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH-1:0] w_next;
   logic             w_at_limit;
   logic [WIDTH-1:0] w_load_q;
   logic             w_count;
   logic             w_wrap_set;
   logic             w_ovf_set;

   mod_limit_detect #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_limit (
      .i_q        (r_q),
      .i_dir      (dir_t'(up)),
      .o_next     (w_next),
      .o_at_limit (w_at_limit)
   );

   // Extra bit on the compare so MOD == 2**WIDTH never clamps.
   always_comb begin
      w_load_q = ({1'b0, load_val} < c_MOD_EXT) ? load_val : c_MAX;
      w_count  = en && !load;
`ifdef CNT_SATURATE_EN
      w_wrap_set = 1'b0;
`else
      w_wrap_set = w_count && w_at_limit;
`endif
      w_ovf_set = w_count && w_at_limit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q    <= WIDTH'(RST_COUNT);
         r_wrap <= RST_WRAP;
         r_ovf  <= RST_OVF;
      end else begin
         if (load) begin
            r_q    <= w_load_q;
            r_wrap <= 1'b0;
         end else if (en) begin
            r_q    <= w_next;
            r_wrap <= w_wrap_set;
         end else begin
            r_wrap <= 1'b0;
         end

         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (clr_flag)
            r_ovf <= 1'b0;
      end
   end

   assign q    = r_q;
   assign qbar = ~r_q;
   assign tc   = w_at_limit;
   assign wrap = r_wrap;
   assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sync_updown_counter.sv
// ============================================================================
//  Module   : tb_sync_updown_counter
//  Brief    : Self-checking bench for sync_updown_counter (WIDTH=4, MOD=10)
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_updown_counter;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_flag;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic             tc;
   logic             wrap;
   logic             ovf;

   int n_vec = 0;
   int n_err = 0;

   int m_q     = 0;
   bit m_wrap  = 1'b0;
   bit m_ovf   = 1'b0;
   bit m_valid = 1'b0;

   sync_updown_counter #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .clr_flag (clr_flag),
      .q        (q),
      .qbar     (qbar),
      .tc       (tc),
      .wrap     (wrap),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, check tc, clock, advance model, check state.
   task automatic apply(input logic rn, input logic en_i, input logic up_i,
                        input logic ld, input logic [WIDTH-1:0] lv,
                        input logic clr);
      int nq;
      bit set;
      rst_n = rn; en = en_i; up = up_i; load = ld; load_val = lv; clr_flag = clr;
      #1;
      if (m_valid)
         check("tc", int'(tc),
               int'((up_i && m_q == MOD-1) || (!up_i && m_q == 0)));
      @(posedge clk);
      set = 1'b0;
      if (!rn) begin
         m_q = 0; m_wrap = 1'b0; m_ovf = 1'b0; m_valid = 1'b1;
      end else begin
         if (ld) begin
            m_q    = (int'(lv) < MOD) ? int'(lv) : MOD-1;
            m_wrap = 1'b0;
         end else if (en_i) begin
`ifdef CNT_SATURATE_EN
            m_wrap = 1'b0;
            if (up_i ? (m_q == MOD-1) : (m_q == 0)) set = 1'b1;
            else m_q = up_i ? m_q + 1 : m_q - 1;
`else
            nq     = up_i ? m_q + 1 : m_q - 1;
            set    = (nq < 0) || (nq >= MOD);
            m_wrap = set;
            m_q    = (nq + MOD) % MOD;
`endif
         end else begin
            m_wrap = 1'b0;
         end
         if (set) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
      #1;
      check("q",    int'(q),    m_q);
      check("qbar", int'(qbar), (~m_q) & ((1 << WIDTH) - 1));
      check("wrap", int'(wrap), int'(m_wrap));
      check("ovf",  int'(ovf),  int'(m_ovf));
   endtask

   initial begin
      apply(0, 0, 1, 0, 4'd0, 0);
      check("rst_q",    int'(q),    0);
      check("rst_qbar", int'(qbar), 15);

      // Mid-count reset, including an asserted load on the reset edge.
      apply(1, 0, 1, 1, 4'd7, 0);
      apply(0, 1, 1, 1, 4'd5, 0);
      check("rst_mid_q", int'(q), 0);
      apply(0, 1, 1, 0, 4'd0, 0);

      // Up-count through the wrap.
      for (int i = 0; i < 12; i++) apply(1, 1, 1, 0, 4'd0, 0);

      // Clear coinciding with a wrap loses; plain clear wins.
      apply(1, 0, 1, 1, 4'd9, 0);
      apply(1, 1, 1, 0, 4'd0, 1);
      check("ovf_set_wins", int'(ovf), 1);
      apply(1, 0, 1, 0, 4'd0, 1);
      check("ovf_cleared", int'(ovf), 0);

      // Down-count from zero.
      apply(1, 0, 0, 1, 4'd0, 0);
      for (int i = 0; i < 3; i++) apply(1, 1, 0, 0, 4'd0, 0);

      // Load clamp with en ignored, then in-range load.
      apply(1, 1, 0, 1, 4'd12, 0);
      check("load_clamp", int'(q), 9);
      apply(1, 1, 1, 1, 4'd3, 0);
      check("load_3", int'(q), 3);

      // Saturation corner (wraps in the default build).
      apply(1, 0, 1, 1, 4'd8, 0);
      for (int i = 0; i < 3; i++) apply(1, 1, 1, 0, 4'd0, 0);
      apply(1, 1, 0, 0, 4'd0, 0);

      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 49) != 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom),
               ($urandom_range(0, 9) == 0),
               4'($urandom),
               ($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
